// File: rtl/axi_stream_traffic_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : axi_stream_traffic_scheduler
//  Description : Gates the AXI-stream traffic generator enable into bursts of
//                a programmed number of beats, separated by an idle gap and
//                repeated a programmed number of times (0 = until stop).
//                Beats are counted from the generator's issue handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module axi_stream_traffic_scheduler #(
    parameter int COUNTER_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic [COUNTER_WIDTH-1:0] burst_length,
    input  logic [COUNTER_WIDTH-1:0] burst_gap,
    input  logic [COUNTER_WIDTH-1:0] n_bursts,
    input  logic                     gen_valid,
    input  logic                     gen_ready,
    output logic                     gen_enable,
    output logic                     busy,
    output logic                     burst_done,
    output logic                     sequence_done,
    output logic                     aborted,
    output logic                     config_error,
    output logic [COUNTER_WIDTH-1:0] bursts_completed
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    localparam logic [COUNTER_WIDTH-1:0] C_ZERO = {COUNTER_WIDTH{1'b0}};
    localparam logic [COUNTER_WIDTH-1:0] C_ONE  = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

    state_t                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] len_q, len_d;
    logic [COUNTER_WIDTH-1:0] gap_q, gap_d;
    logic [COUNTER_WIDTH-1:0] nb_q, nb_d;
    logic [COUNTER_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [COUNTER_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
    logic [COUNTER_WIDTH-1:0] bursts_completed_q, bursts_completed_d;
    logic                     gen_enable_q, gen_enable_d;
    logic                     busy_q, busy_d;
    logic                     burst_done_q, burst_done_d;
    logic                     sequence_done_q, sequence_done_d;
    logic                     aborted_q, aborted_d;
    logic                     config_error_q, config_error_d;

    // The generator fetches a word in the cycle it is enabled, downstream is
    // ready and it is not already presenting one.
    logic                     issue;
    logic [COUNTER_WIDTH-1:0] bursts_inc;

    assign issue      = gen_enable_q & gen_ready & ~gen_valid;
    assign bursts_inc = bursts_completed_q + C_ONE;

    // Next-state, counter and pulse logic; every output is re-registered so
    // gen_enable and the status pulses never follow inputs combinationally.
    always_comb begin
        state_d            = state_q;
        len_d              = len_q;
        gap_d              = gap_q;
        nb_d               = nb_q;
        beat_cnt_d         = beat_cnt_q;
        gap_cnt_d          = gap_cnt_q;
        bursts_completed_d = bursts_completed_q;
        burst_done_d       = 1'b0;
        sequence_done_d    = 1'b0;
        aborted_d          = 1'b0;
        config_error_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // stop in the same cycle as start suppresses everything
                if (start && !stop) begin
                    if (burst_length == C_ZERO) begin
                        config_error_d = 1'b1;
                    end else begin
                        len_d              = burst_length;
                        gap_d              = burst_gap;
                        nb_d               = n_bursts;
                        beat_cnt_d         = C_ZERO;
                        bursts_completed_d = C_ZERO;
                        state_d            = S_BURST;
                    end
                end
            end
            S_BURST: begin
                if (stop) begin
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (issue) begin
                    if (beat_cnt_q == len_q - C_ONE) begin
                        state_d = S_DRAIN;
                    end else begin
                        beat_cnt_d = beat_cnt_q + C_ONE;
                    end
                end
            end
            S_DRAIN: begin
                // the last beat is on the bus this cycle; the burst only
                // counts if it is not aborted here
                if (stop) begin
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    burst_done_d       = 1'b1;
                    bursts_completed_d = bursts_inc;
                    if ((nb_q != C_ZERO) && (bursts_inc == nb_q)) begin
                        sequence_done_d = 1'b1;
                        state_d         = S_IDLE;
                    end else if (gap_q == C_ZERO) begin
                        beat_cnt_d = C_ZERO;
                        state_d    = S_BURST;
                    end else begin
                        gap_cnt_d = C_ZERO;
                        state_d   = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (stop) begin
                    aborted_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (gap_cnt_q == gap_q - C_ONE) begin
                    beat_cnt_d = C_ZERO;
                    state_d    = S_BURST;
                end else begin
                    gap_cnt_d = gap_cnt_q + C_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        gen_enable_d = (state_d == S_BURST);
        busy_d       = (state_d != S_IDLE);
    end

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q            <= S_IDLE;
            len_q              <= C_ZERO;
            gap_q              <= C_ZERO;
            nb_q               <= C_ZERO;
            beat_cnt_q         <= C_ZERO;
            gap_cnt_q          <= C_ZERO;
            bursts_completed_q <= C_ZERO;
            gen_enable_q       <= 1'b0;
            busy_q             <= 1'b0;
            burst_done_q       <= 1'b0;
            sequence_done_q    <= 1'b0;
            aborted_q          <= 1'b0;
            config_error_q     <= 1'b0;
        end else begin
            state_q            <= state_d;
            len_q              <= len_d;
            gap_q              <= gap_d;
            nb_q               <= nb_d;
            beat_cnt_q         <= beat_cnt_d;
            gap_cnt_q          <= gap_cnt_d;
            bursts_completed_q <= bursts_completed_d;
            gen_enable_q       <= gen_enable_d;
            busy_q             <= busy_d;
            burst_done_q       <= burst_done_d;
            sequence_done_q    <= sequence_done_d;
            aborted_q          <= aborted_d;
            config_error_q     <= config_error_d;
        end
    end

    assign gen_enable       = gen_enable_q;
    assign busy             = busy_q;
    assign burst_done       = burst_done_q;
    assign sequence_done    = sequence_done_q;
    assign aborted          = aborted_q;
    assign config_error     = config_error_q;
    assign bursts_completed = bursts_completed_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_traffic_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_stream_traffic_scheduler
//  Description : Directed self-checking bench for the traffic scheduler with a
//                behavioural one-beat-per-fetch generator model attached.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_stream_traffic_scheduler;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         stop  = 1'b0;
    logic [W-1:0] burst_length = '0;
    logic [W-1:0] burst_gap    = '0;
    logic [W-1:0] n_bursts     = '0;
    logic         gen_valid;
    logic         gen_ready = 1'b1;
    logic         gen_enable;
    logic         busy;
    logic         burst_done;
    logic         sequence_done;
    logic         aborted;
    logic         config_error;
    logic [W-1:0] bursts_completed;

    int checks = 0;
    int errors = 0;

    // running event counts, sampled on the falling edge
    int valid_cnt   = 0;
    int valid_dis   = 0;
    int bdone_cnt   = 0;
    int sdone_cnt   = 0;

    axi_stream_traffic_scheduler #(.COUNTER_WIDTH(W)) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .stop             (stop),
        .burst_length     (burst_length),
        .burst_gap        (burst_gap),
        .n_bursts         (n_bursts),
        .gen_valid        (gen_valid),
        .gen_ready        (gen_ready),
        .gen_enable       (gen_enable),
        .busy             (busy),
        .burst_done       (burst_done),
        .sequence_done    (sequence_done),
        .aborted          (aborted),
        .config_error     (config_error),
        .bursts_completed (bursts_completed)
    );

    always #5 clock = ~clock;

    // Generator model: fetch when enabled, ready and idle; present one cycle.
    always @(posedge clock) begin
        if (!reset) gen_valid <= 1'b0;
        else        gen_valid <= gen_enable & gen_ready & ~gen_valid;
    end

    // Event counters.
    always @(negedge clock) begin
        valid_cnt <= valid_cnt + int'(gen_valid);
        valid_dis <= valid_dis + int'(gen_valid & ~gen_enable);
        bdone_cnt <= bdone_cnt + int'(burst_done);
        sdone_cnt <= sdone_cnt + int'(sequence_done);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // advance to just after the next falling edge
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " gen_enable"},       32'(gen_enable),       0);
        check({tag, " busy"},             32'(busy),             0);
        check({tag, " burst_done"},       32'(burst_done),       0);
        check({tag, " sequence_done"},    32'(sequence_done),    0);
        check({tag, " aborted"},          32'(aborted),          0);
        check({tag, " config_error"},     32'(config_error),     0);
        check({tag, " bursts_completed"}, 32'(bursts_completed), 0);
    endtask

    initial begin
        int s;
        int base_v, base_vd, base_b, base_s;
        int low;

        // ---------------- reset state ----------------
        reset = 1'b0;
        step(); step();
        check_all_zero("reset");
        reset = 1'b1;
        step();

        // ---------------- single burst L=4 N=1 G=0 ----------------
        burst_length = 16'd4; burst_gap = 16'd0; n_bursts = 16'd1;
        base_v = valid_cnt; base_b = bdone_cnt; base_s = sdone_cnt;
        start = 1'b1;
        step(); start = 1'b0;                           // cycle k+1
        check("single en@1",   32'(gen_enable), 1);
        check("single busy@1", 32'(busy), 1);
        repeat (6) step();                              // k+7
        check("single en@7",   32'(gen_enable), 1);
        step();                                         // k+8 drain
        check("single en@8",    32'(gen_enable), 0);
        check("single valid@8", 32'(gen_valid), 1);
        check("single busy@8",  32'(busy), 1);
        step();                                         // k+9
        check("single bdone@9", 32'(burst_done), 1);
        check("single sdone@9", 32'(sequence_done), 1);
        check("single busy@9",  32'(busy), 0);
        check("single cnt@9",   32'(bursts_completed), 1);
        check("single beats",   32'(valid_cnt - base_v), 4);
        step();
        check("single bdone@10", 32'(burst_done), 0);
        check("single bdones",   32'(bdone_cnt - base_b), 1);
        check("single sdones",   32'(sdone_cnt - base_s), 1);

        // -------- multi-burst L=3 G=5 N=3, with ignored mid-run start --------
        burst_length = 16'd3; burst_gap = 16'd5; n_bursts = 16'd3;
        base_v = valid_cnt; base_b = bdone_cnt; base_s = sdone_cnt;
        start = 1'b1;
        step(); start = 1'b0; s = 1;
        // new configuration plus start while busy must change nothing
        burst_length = 16'd7; burst_gap = 16'd0; n_bursts = 16'd1;
        start = 1'b1;
        step(); start = 1'b0; s++;
        repeat (3) begin step(); s++; end               // s = 5
        check("multi en@5", 32'(gen_enable), 1);
        low = 0;
        for (int i = 0; i < 20; i++) begin
            step(); s++;
            if (gen_enable) break;
            low++;
        end
        check("multi gap low cycles", 32'(low), 6);
        check("multi resume s",       32'(s), 12);
        for (int i = 0; i < 100 && !sequence_done; i++) begin step(); s++; end
        check("multi sdone seen",   32'(sequence_done), 1);
        check("multi sdone cycle",  32'(s), 29);
        check("multi beats",        32'(valid_cnt - base_v), 9);
        check("multi bdones",       32'(bdone_cnt - base_b), 3);
        check("multi sdones",       32'(sdone_cnt - base_s), 1);
        check("multi cnt",          32'(bursts_completed), 3);
        check("multi busy",         32'(busy), 0);

        // ---------------- backpressure L=2 random ready ----------------
        burst_length = 16'd2; burst_gap = 16'd0; n_bursts = 16'd1;
        step();
        base_v = valid_cnt; base_vd = valid_dis; base_s = sdone_cnt;
        gen_ready = 1'b0;
        start = 1'b1;
        step(); start = 1'b0;
        repeat (4) step();
        check("bp stall en", 32'(gen_enable), 1);
        check("bp stall beats", 32'(valid_cnt - base_v), 0);
        for (int i = 0; i < 300 && !sequence_done; i++) begin
            gen_ready = 1'($urandom_range(0, 1));
            step();
        end
        gen_ready = 1'b1;
        check("bp sdone seen",       32'(sequence_done), 1);
        check("bp beats",            32'(valid_cnt - base_v), 2);
        check("bp beats while dis",  32'(valid_dis - base_vd), 1);
        check("bp cnt",              32'(bursts_completed), 1);

        // ------------- infinite L=2 G=1 N=0, abort after 5 bursts -------------
        burst_length = 16'd2; burst_gap = 16'd1; n_bursts = 16'd0;
        base_b = bdone_cnt; base_s = sdone_cnt;
        start = 1'b1;
        step(); start = 1'b0;
        for (int i = 0; i < 200 && (bdone_cnt - base_b) < 5; i++) step();
        check("inf bdones", 32'(bdone_cnt - base_b), 5);
        check("inf bdone now", 32'(burst_done), 1);       // gap cycle
        step();
        check("inf en before stop", 32'(gen_enable), 1);
        stop = 1'b1;
        step(); stop = 1'b0;
        check("inf aborted",  32'(aborted), 1);
        check("inf en",       32'(gen_enable), 0);
        check("inf busy",     32'(busy), 0);
        check("inf cnt",      32'(bursts_completed), 5);
        check("inf sdones",   32'(sdone_cnt - base_s), 0);
        step();
        check("inf aborted pulse", 32'(aborted), 0);
        check("inf cnt hold",      32'(bursts_completed), 5);

        // ---------------- illegal and conflicting starts ----------------
        burst_length = 16'd0;
        start = 1'b1;
        step(); start = 1'b0;
        check("illegal cfg_err", 32'(config_error), 1);
        check("illegal busy",    32'(busy), 0);
        check("illegal en",      32'(gen_enable), 0);
        step();
        check("illegal cfg_err pulse", 32'(config_error), 0);
        start = 1'b1; stop = 1'b1;                        // L=0 still
        step(); start = 1'b0; stop = 1'b0;
        check("conflict0 cfg_err", 32'(config_error), 0);
        check("conflict0 busy",    32'(busy), 0);
        burst_length = 16'd3;
        start = 1'b1; stop = 1'b1;
        step(); start = 1'b0; stop = 1'b0;
        check("conflict busy",    32'(busy), 0);
        check("conflict en",      32'(gen_enable), 0);
        check("conflict aborted", 32'(aborted), 0);
        stop = 1'b1;
        step(); stop = 1'b0;
        check("idle stop aborted", 32'(aborted), 0);
        check("idle cnt kept",     32'(bursts_completed), 5);

        // ---------------- reset mid-burst L=8 ----------------
        burst_length = 16'd8; burst_gap = 16'd0; n_bursts = 16'd1;
        start = 1'b1;
        step(); start = 1'b0;
        repeat (3) step();                                // 2nd beat presented
        check("rst mid en", 32'(gen_enable), 1);
        reset = 1'b0;
        step();
        check_all_zero("rst mid");
        reset = 1'b1;
        step();
        base_v = valid_cnt;
        start = 1'b1;
        step(); start = 1'b0; s = 1;
        for (int i = 0; i < 100 && !sequence_done; i++) begin step(); s++; end
        check("rst rerun sdone", 32'(sequence_done), 1);
        check("rst rerun cycle", 32'(s), 17);
        check("rst rerun beats", 32'(valid_cnt - base_v), 8);
        check("rst rerun cnt",   32'(bursts_completed), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
